// File: rtl/fw_dut_emu_pkg.sv
// Shared types and constants for the FW config-chain DUT emulator.
// Optional bit counter feature: FW_DUT_CFG_EMU_BITCNT_EN.
package fw_dut_emu_pkg;

  typedef enum logic [1:0] {
    ST_RST,
    ST_IDLE,
    ST_LOAD
  } emu_state_t;

  localparam int unsigned EMU_BITCNT_W = 16;
  localparam logic [EMU_BITCNT_W-1:0] EMU_BITCNT_MAX = '1;

  // Saturating increment for the accepted-shift counter
  function automatic logic [EMU_BITCNT_W-1:0] bitcnt_inc(input logic [EMU_BITCNT_W-1:0] cnt);
    return (cnt == EMU_BITCNT_MAX) ? cnt : cnt + EMU_BITCNT_W'(1);
  endfunction

endpackage

// File: rtl/fw_dut_cfg_chain_emu_edge_det.sv
// One-register rising-edge detector for FW-generated level signals.
// Inputs are already in the fw_clk domain, so no synchronizer stages.
module fw_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_d;

  // Delayed copy of the level used to spot the 0->1 transition
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_d <= 1'b0;
    end else begin
      sig_d <= sig;
    end
  end

  assign rise = sig & ~sig_d;

endmodule

// File: rtl/fw_dut_cfg_chain_emu.sv
// DUT-side responder for the FW config-chain shift protocol. Emulates the
// ASIC config chain so FW IPs can be exercised as a loopback target.
// Optional feature macro: FW_DUT_CFG_EMU_BITCNT_EN (adds emu_bit_cnt).
module fw_dut_cfg_chain_emu
  import fw_dut_emu_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 16,
  parameter int unsigned LOAD_LAT  = 2
) (
  input  logic                    fw_clk,
  input  logic                    fw_rst,
  input  logic                    fw_reset_not,
  input  logic                    fw_config_clk,
  input  logic                    fw_config_in,
  input  logic                    fw_config_load,
  output logic                    fw_config_out,
  output logic [CHAIN_LEN-1:0]    emu_cfg_word,
  output logic                    emu_cfg_update,
  output logic                    emu_err_sticky,
  input  logic                    emu_err_clear
`ifdef FW_DUT_CFG_EMU_BITCNT_EN
  ,
  output logic [EMU_BITCNT_W-1:0] emu_bit_cnt
`endif
);

  localparam int unsigned LAT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  emu_state_t           state;
  logic [CHAIN_LEN-1:0] chain;
  logic [LAT_W-1:0]     lat_cnt;
  logic                 clk_rise;
  logic                 load_rise;

  fw_edge_det u_clk_edge (
    .clk  (fw_clk),
    .rst  (fw_rst),
    .sig  (fw_config_clk),
    .rise (clk_rise)
  );

  fw_edge_det u_load_edge (
    .clk  (fw_clk),
    .rst  (fw_rst),
    .sig  (fw_config_load),
    .rise (load_rise)
  );

  // Chain FSM: shift, load latency countdown, shadow update and error flag
  always_ff @(posedge fw_clk) begin
    if (fw_rst) begin
      state          <= ST_RST;
      chain          <= '0;
      lat_cnt        <= '0;
      fw_config_out  <= 1'b0;
      emu_cfg_word   <= '0;
      emu_cfg_update <= 1'b0;
      emu_err_sticky <= 1'b0;
`ifdef FW_DUT_CFG_EMU_BITCNT_EN
      emu_bit_cnt    <= '0;
`endif
    end else begin
      emu_cfg_update <= 1'b0;
      fw_config_out  <= chain[CHAIN_LEN-1];

      // Set has priority over a simultaneous clear
      if (clk_rise && (state == ST_LOAD)) begin
        emu_err_sticky <= 1'b1;
      end else if (emu_err_clear) begin
        emu_err_sticky <= 1'b0;
      end

      if (!fw_reset_not) begin
        state        <= ST_RST;
        chain        <= '0;
        emu_cfg_word <= '0;
        lat_cnt      <= '0;
`ifdef FW_DUT_CFG_EMU_BITCNT_EN
        emu_bit_cnt  <= '0;
`endif
      end else begin
        case (state)
          ST_RST: begin
            chain        <= '0;
            emu_cfg_word <= '0;
`ifdef FW_DUT_CFG_EMU_BITCNT_EN
            emu_bit_cnt  <= '0;
`endif
            state        <= ST_IDLE;
          end
          ST_IDLE: begin
            // Shift and load may coincide: shadow later captures the shifted chain
            if (clk_rise) begin
              chain <= {chain[CHAIN_LEN-2:0], fw_config_in};
`ifdef FW_DUT_CFG_EMU_BITCNT_EN
              emu_bit_cnt <= bitcnt_inc(emu_bit_cnt);
`endif
            end
            if (load_rise) begin
              lat_cnt <= LAT_W'(LOAD_LAT - 1);
              state   <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            if (lat_cnt == '0) begin
              emu_cfg_word   <= chain;
              emu_cfg_update <= 1'b1;
`ifdef FW_DUT_CFG_EMU_BITCNT_EN
              emu_bit_cnt    <= '0;
`endif
              state          <= ST_IDLE;
            end else begin
              lat_cnt <= lat_cnt - LAT_W'(1);
            end
          end
          default: begin
            state <= ST_RST;
          end
        endcase
      end
    end
  end

endmodule
